sync_fifo_param: RTL and testbench

//  Parametrised synchronous FIFO (DATA_W x DEPTH); successor to the fixed 3x8 FIFO.

---
 rtl/sync_fifo_param.sv | 78 +++++++
 tb/tb_sync_fifo_param.sv | 176 +++++++++++++++++
 2 files changed

// File: rtl/sync_fifo_param.sv
// Parametrised single-clock FIFO with arbitrary depth, occupancy and programmable level flags.
// Optional sticky overflow/underflow flags are built only when SYNC_FIFO_ERR_FLAGS_EN is defined.
module sync_fifo_param #(
  parameter int DATA_W    = 8,
  parameter int DEPTH     = 16,
  parameter int AF_THRESH = 14,
  parameter int AE_THRESH = 2
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       wr_en,
  input  logic [DATA_W-1:0]          data_in,
  input  logic                       rd_en,
  output logic [DATA_W-1:0]          data_out,
  output logic                       full,
  output logic                       empty,
  output logic                       almost_full,
  output logic                       almost_empty,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       overflow,
  output logic                       underflow
);
  localparam int CW = $clog2(DEPTH+1);
  localparam int PW = $clog2(DEPTH);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [PW-1:0]     wr_ptr, rd_ptr;
  logic              rd_acc, wr_acc;

  assign full         = (count == CW'(DEPTH));
  assign empty        = (count == '0);
  assign almost_full  = (count >= CW'(AF_THRESH));
  assign almost_empty = (count <= CW'(AE_THRESH));

  // A full FIFO still takes a write when the head is leaving in the same cycle.
  assign rd_acc = rd_en && !empty;
  assign wr_acc = wr_en && (!full || rd_acc);

  always_ff @(posedge clk) begin
    if (wr_acc) mem[wr_ptr] <= data_in;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      data_out <= '0;
    end else begin
      if (wr_acc) wr_ptr <= (wr_ptr == PW'(DEPTH-1)) ? '0 : wr_ptr + 1'b1;
      if (rd_acc) begin
        rd_ptr   <= (rd_ptr == PW'(DEPTH-1)) ? '0 : rd_ptr + 1'b1;
        data_out <= mem[rd_ptr];
      end
      case ({wr_acc, rd_acc})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

`ifdef SYNC_FIFO_ERR_FLAGS_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (wr_en && !wr_acc) overflow  <= 1'b1;
      if (rd_en && !rd_acc) underflow <= 1'b1;
    end
  end
`else
  assign overflow  = 1'b0;
  assign underflow = 1'b0;
`endif

endmodule

// File: tb/tb_sync_fifo_param.sv
// Directed bench: a DEPTH=16 instance for fill/drain/overflow/reset, a DEPTH=5 instance for wrap and full+rd/wr.
module tb_sync_fifo_param;
  logic clk = 0;
  logic rst = 0;
  always #5 clk = ~clk;

`ifdef SYNC_FIFO_ERR_FLAGS_EN
  localparam logic ERR = 1'b1;
`else
  localparam logic ERR = 1'b0;
`endif

  int n_cmp = 0;
  int n_err = 0;

  logic       a_wr = 0, a_rd = 0;
  logic [7:0] a_din = 0, a_dout;
  logic       a_full, a_empty, a_af, a_ae, a_ovf, a_unf;
  logic [4:0] a_cnt;

  logic       b_wr = 0, b_rd = 0;
  logic [7:0] b_din = 0, b_dout;
  logic       b_full, b_empty, b_af, b_ae, b_ovf, b_unf;
  logic [2:0] b_cnt;

  sync_fifo_param #(.DATA_W(8), .DEPTH(16), .AF_THRESH(14), .AE_THRESH(2)) u_a (
    .clk(clk), .rst(rst), .wr_en(a_wr), .data_in(a_din), .rd_en(a_rd), .data_out(a_dout),
    .full(a_full), .empty(a_empty), .almost_full(a_af), .almost_empty(a_ae),
    .count(a_cnt), .overflow(a_ovf), .underflow(a_unf));

  sync_fifo_param #(.DATA_W(8), .DEPTH(5), .AF_THRESH(4), .AE_THRESH(1)) u_b (
    .clk(clk), .rst(rst), .wr_en(b_wr), .data_in(b_din), .rd_en(b_rd), .data_out(b_dout),
    .full(b_full), .empty(b_empty), .almost_full(b_af), .almost_empty(b_ae),
    .count(b_cnt), .overflow(b_ovf), .underflow(b_unf));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic a_cyc(input logic w, input logic [7:0] d, input logic r);
    a_wr = w; a_din = d; a_rd = r;
    @(posedge clk); #1;
    a_wr = 0; a_rd = 0;
  endtask

  task automatic b_cyc(input logic w, input logic [7:0] d, input logic r);
    b_wr = w; b_din = d; b_rd = r;
    @(posedge clk); #1;
    b_wr = 0; b_rd = 0;
  endtask

  task automatic do_rst();
    rst = 1;
    @(posedge clk); #1;
    rst = 0;
  endtask

  initial begin
    int rd_idx;
    // Reset state
    do_rst();
    chk("rst_count", a_cnt, 0);
    chk("rst_empty", a_empty, 1);
    chk("rst_full", a_full, 0);
    chk("rst_ae", a_ae, 1);
    chk("rst_af", a_af, 0);
    chk("rst_dout", a_dout, 0);
    chk("rst_ovf", a_ovf, 0);
    chk("rst_unf", a_unf, 0);

    // Fill 0x00..0x0F
    for (int i = 0; i < 16; i++) begin
      a_cyc(1, 8'(i), 0);
      chk("fill_count", a_cnt, i + 1);
      chk("fill_af", a_af, (i + 1 >= 14));
      chk("fill_ae", a_ae, (i + 1 <= 2));
      chk("fill_full", a_full, (i + 1 == 16));
    end

    // Write while full without read: dropped
    a_cyc(1, 8'hEE, 0);
    chk("ovf_count", a_cnt, 16);
    chk("ovf_flag", a_ovf, ERR);
    a_cyc(0, 0, 0);
    chk("ovf_sticky", a_ovf, ERR);

    // Drain in order, one cycle after each read
    for (int i = 0; i < 16; i++) begin
      a_cyc(0, 0, 1);
      chk("drain_data", a_dout, i);
      chk("drain_count", a_cnt, 15 - i);
    end
    chk("drain_empty", a_empty, 1);
    a_cyc(0, 0, 1);
    chk("unf_dout_hold", a_dout, 8'h0F);
    chk("unf_flag", a_unf, ERR);
    chk("unf_ovf_sticky", a_ovf, ERR);

    // Reset clears sticky flags and data_out
    do_rst();
    chk("rst2_ovf", a_ovf, 0);
    chk("rst2_unf", a_unf, 0);
    chk("rst2_dout", a_dout, 0);
    chk("rst2_count", a_cnt, 0);

    // Empty + simultaneous rd/wr: no bypass
    a_cyc(1, 8'h3C, 1);
    chk("er_count", a_cnt, 1);
    chk("er_dout", a_dout, 0);
    chk("er_unf", a_unf, ERR);
    a_cyc(0, 0, 1);
    chk("er_read", a_dout, 8'h3C);
    chk("er_empty", a_empty, 1);

    // Reset mid-operation with wr_en/rd_en both high
    do_rst();
    for (int i = 0; i < 8; i++) a_cyc(1, 8'(8'h70 + i), 0);
    a_cyc(0, 0, 1);
    chk("mid_dout", a_dout, 8'h70);
    chk("mid_count", a_cnt, 7);
    a_wr = 1; a_din = 8'h99; a_rd = 1; rst = 1;
    @(posedge clk); #1;
    a_wr = 0; a_rd = 0; rst = 0;
    chk("mid_rst_count", a_cnt, 0);
    chk("mid_rst_empty", a_empty, 1);
    chk("mid_rst_ae", a_ae, 1);
    chk("mid_rst_dout", a_dout, 0);

    // DEPTH=5 wrap: 2-in/1-out, then write+read pairs, then drain
    rd_idx = 0;
    for (int g = 0; g < 4; g++) begin
      b_cyc(1, 8'(8'hA0 + 2*g), 0);
      b_cyc(1, 8'(8'hA1 + 2*g), 0);
      b_cyc(0, 0, 1);
      chk("wrap_data", b_dout, 8'hA0 + rd_idx);
      rd_idx++;
    end
    chk("wrap_count4", b_cnt, 4);
    chk("wrap_af", b_af, 1);
    for (int i = 0; i < 4; i++) begin
      b_cyc(1, 8'(8'hA8 + i), 1);
      chk("wrap_pair_data", b_dout, 8'hA0 + rd_idx);
      chk("wrap_pair_count", b_cnt, 4);
      rd_idx++;
    end
    for (int i = 0; i < 4; i++) begin
      b_cyc(0, 0, 1);
      chk("wrap_drain", b_dout, 8'hA0 + rd_idx);
      rd_idx++;
    end
    chk("wrap_empty", b_empty, 1);

    // Full + simultaneous rd/wr
    for (int i = 0; i < 5; i++) b_cyc(1, 8'(8'h11 + i), 0);
    chk("fb_full", b_full, 1);
    chk("fb_count", b_cnt, 5);
    b_cyc(1, 8'h55, 1);
    chk("fb_dout", b_dout, 8'h11);
    chk("fb_count_hold", b_cnt, 5);
    chk("fb_full_hold", b_full, 1);
    chk("fb_ovf", b_ovf, 0);
    b_cyc(0, 0, 1); chk("fb_r1", b_dout, 8'h12);
    b_cyc(0, 0, 1); chk("fb_r2", b_dout, 8'h13);
    b_cyc(0, 0, 1); chk("fb_r3", b_dout, 8'h14);
    b_cyc(0, 0, 1); chk("fb_r4", b_dout, 8'h15);
    b_cyc(0, 0, 1); chk("fb_r5", b_dout, 8'h55);
    chk("fb_empty", b_empty, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
